spi_master_sched: RTL and testbench

//  Round-robin scheduler that shares one SPI bit-level master datapath between NREQ requesters.
//  Per frame: picks a requester, latches its outbound data, drives the datapath sequencing
//  (selected/cnt/ready), asserts that requester's slave select, and returns the received data.

---
 rtl/spi_master_sched_if.sv | 37 +++
 rtl/spi_master_sched.sv | 122 ++++++++++++
 tb/tb_spi_master_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_sched_if.sv
// Bundle between user logic / SPI datapath and the round-robin scheduler.
// Ports: req/req_dat/grant/done/rsp_dat (requesters), ss_n/sclk (bus),
//        selected/ready/cnt/mdat/sdat (bit-level datapath).
interface spi_master_sched_if #(
    parameter int NREQ  = 2,
    parameter int BYTES = 1
);
    localparam int DW = 8 * BYTES;
    localparam int CW = 4 + BYTES;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_dat;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rsp_dat;
    logic [NREQ-1:0]    ss_n;
    logic               sclk;
    logic               selected;
    logic               ready;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      mdat;
    logic [DW-1:0]      sdat;

    // master: requesters plus datapath environment
    modport master (
        output req, req_dat, sdat,
        input  grant, done, rsp_dat, ss_n, sclk,
        input  selected, ready, cnt, mdat
    );

    // slave: the scheduler itself
    modport slave (
        input  req, req_dat, sdat,
        output grant, done, rsp_dat, ss_n, sclk,
        output selected, ready, cnt, mdat
    );
endinterface

// File: rtl/spi_master_sched.sv
// Round-robin scheduler sharing one SPI bit-level datapath among NREQ requesters.
// Ports: clk, reset (async, active-low), bus (spi_master_sched_if.slave).
module spi_master_sched #(
    parameter int NREQ      = 2,
    parameter int BYTES     = 1,
    parameter int GAP_TICKS = 2
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_sched_if.slave   bus
);
    localparam int DW   = 8 * BYTES;
    localparam int CW   = 4 + BYTES;
    localparam int BITS = 8 * BYTES + 2;
    localparam int LAST = 2 * BITS - 1;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, DONE, GAP
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q;
    logic [GW-1:0]   gcnt;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic [DW-1:0]   rsp_q;
    logic [NREQ-1:0] ss_n_q;
    logic            sel_q;
    logic            rdy_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   mdat_q;

    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            found;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win_q   <= '0;
            gcnt    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            rsp_q   <= '0;
            ss_n_q  <= '1;
            sel_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            mdat_q  <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            rdy_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state   <= SETUP;
                        win_q   <= pick;
                        grant_q <= NREQ'(1) << pick;
                        mdat_q  <= bus.req_dat[pick*DW +: DW];
                        ss_n_q  <= ~(NREQ'(1) << pick);
                        sel_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SETUP: state <= SHIFT;
                SHIFT: begin
                    if (cnt_q == CW'(LAST)) begin
                        state  <= DONE;
                        rdy_q  <= 1'b1;
                        done_q <= NREQ'(1) << win_q;
                        ptr    <= PW'((int'(win_q) + 1) % NREQ);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    rsp_q  <= bus.sdat;
                    ss_n_q <= '1;
                    sel_q  <= 1'b0;
                    cnt_q  <= '0;
                    gcnt   <= '0;
                    // IDLE is the last gap cycle, so GAP covers the rest.
                    state  <= (GAP_TICKS > 1) ? GAP : IDLE;
                end
                GAP: begin
                    if (int'(gcnt) == GAP_TICKS - 2) state <= IDLE;
                    else gcnt <= gcnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.rsp_dat  = rsp_q;
    assign bus.ss_n     = ss_n_q;
    assign bus.sclk     = sel_q & cnt_q[0];
    assign bus.selected = sel_q;
    assign bus.ready    = rdy_q;
    assign bus.cnt      = cnt_q;
    assign bus.mdat     = mdat_q;
endmodule

// File: tb/tb_spi_master_sched.sv
// Scoreboard bench for spi_master_sched: 2x8-bit loopback and 2x16-bit instances.
// Ports: none (drives clk, reset and both interfaces).
module tb_spi_master_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_sched_if #(.NREQ(2), .BYTES(1)) b1();
    spi_master_sched_if #(.NREQ(2), .BYTES(2)) b2();

    spi_master_sched #(.NREQ(2), .BYTES(1), .GAP_TICKS(2)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    spi_master_sched #(.NREQ(2), .BYTES(2), .GAP_TICKS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    assign b1.sdat = b1.mdat;
    assign b2.sdat = 16'hBEEF;

    typedef struct {
        int          idx;
        logic [15:0] dat;
        int          gexp;
        int          gcyc;
    } exp_t;

    exp_t sq[$];
    exp_t act[$];
    exp_t me;
    exp_t pend;
    bit   rsp_pend = 0;
    int   cyc = 0, tests = 0, fails = 0, viol = 0, cmax = 0;
    int   g2 = 0, cmax2 = 0, n2 = 0;
    bit   rsp2 = 0;
    logic [1:0] sexp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) if (reset) begin
        if (rsp_pend) begin
            chk("rsp_dat", b1.rsp_dat, pend.dat);
            rsp_pend = 0;
        end
        if ($countones(~b1.ss_n) > 1 || (b1.ss_n != 2'b11 && !b1.selected))
            viol++;
        if (b1.selected && int'(b1.cnt) > cmax) cmax = int'(b1.cnt);
        if (b1.grant != 0) begin
            if (sq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_grant: got %b expected none", b1.grant);
            end else begin
                me = sq.pop_front();
                sexp = ~(2'b01 << me.idx);
                chk("grant", b1.grant, 1 << me.idx);
                chk("grant_cycle", cyc, me.gexp);
                chk("ss_n_at_grant", b1.ss_n, sexp);
                chk("mdat", b1.mdat, me.dat[7:0]);
                me.gcyc = cyc;
                cmax = 0;
                act.push_back(me);
            end
        end
        if (b1.done != 0) begin
            if (act.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got %b expected none", b1.done);
            end else begin
                me = act.pop_front();
                chk("done", b1.done, 1 << me.idx);
                chk("done_latency", cyc - me.gcyc, 21);
                chk("ready", b1.ready, 1);
                chk("cnt_max", cmax, 19);
                pend = me;
                rsp_pend = 1;
            end
        end
    end

    // Monitor for the 16-bit instance (fixed slave data 16'hBEEF)
    always @(negedge clk) if (reset) begin
        if (rsp2) begin
            chk("rsp_dat_16", b2.rsp_dat, 16'hBEEF);
            rsp2 = 0;
            n2++;
        end
        if (b2.selected && int'(b2.cnt) > cmax2) cmax2 = int'(b2.cnt);
        if (b2.grant != 0) begin
            chk("grant_16", b2.grant, 1);
            chk("mdat_16", b2.mdat, 16'h1234);
            g2 = cyc;
            cmax2 = 0;
        end
        if (b2.done != 0) begin
            chk("done_16", b2.done, 1);
            chk("done_latency_16", cyc - g2, 37);
            chk("cnt_max_16", cmax2, 35);
            rsp2 = 1;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int idx, logic [15:0] d, int gexp);
        exp_t e;
        e.idx = idx; e.dat = d; e.gexp = gexp; e.gcyc = 0;
        sq.push_back(e);
    endtask

    task automatic wait_grants(int budget);
        int k = 0;
        while (sq.size() != 0 && k < budget) begin tick(); k++; end
        chk("grant_timeout", sq.size(), 0);
        sq.delete();
    endtask

    task automatic wait_all(int budget);
        int k = 0;
        while ((sq.size() != 0 || act.size() != 0 || rsp_pend) && k < budget) begin
            tick(); k++;
        end
        chk("drain_timeout", sq.size() + act.size() + int'(rsp_pend), 0);
        sq.delete(); act.delete(); rsp_pend = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        sq.delete(); act.delete(); rsp_pend = 0;
        tick(2);
        reset = 1;
    endtask

    initial begin
        int k;
        logic [31:0] c7;
        reset = 0;
        b1.req = '0; b1.req_dat = '0;
        b2.req = '0; b2.req_dat = '0;
        tick(3);
        chk("rst_grant", b1.grant, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_rsp_dat", b1.rsp_dat, 0);
        chk("rst_ss_n", b1.ss_n, 2'b11);
        chk("rst_sclk", b1.sclk, 0);
        chk("rst_selected", b1.selected, 0);
        chk("rst_ready", b1.ready, 0);
        chk("rst_cnt", b1.cnt, 0);
        chk("rst_mdat", b1.mdat, 0);
        reset = 1;
        tick(100);
        chk("idle_ss_n", b1.ss_n, 2'b11);

        // single frame, loopback
        b1.req_dat = 16'h3CA5;
        push(0, 16'h00A5, cyc + 1);
        b1.req = 2'b01;
        wait_all(40);
        b1.req = 2'b00;
        do_reset();

        // both held: alternate 0,1,0,1 every 24 cycles
        b1.req_dat = 16'hC35A;
        push(0, 16'h005A, cyc + 1);
        push(1, 16'h00C3, cyc + 25);
        push(0, 16'h005A, cyc + 49);
        push(1, 16'h00C3, cyc + 73);
        b1.req = 2'b11;
        wait_grants(100);
        b1.req = 2'b00;
        wait_all(40);

        // short req[1] pulse during frame 0 is withdrawn
        b1.req_dat = 16'h0077;
        push(0, 16'h0077, cyc + 1);
        b1.req = 2'b01;
        tick(5);
        b1.req = 2'b11;
        tick();
        b1.req = 2'b01;
        wait_all(40);
        b1.req = 2'b00;
        tick(40);

        // reset mid-frame at cnt=7
        b1.req_dat = 16'h2211;
        push(0, 16'h0011, cyc + 1);
        b1.req = 2'b01;
        k = 0;
        while (b1.cnt != 7 && k < 50) begin tick(); k++; end
        c7 = 32'(b1.cnt);
        chk("cnt_before_reset", c7, 7);
        reset = 0;
        #1;
        chk("midrst_ss_n", b1.ss_n, 2'b11);
        chk("midrst_selected", b1.selected, 0);
        chk("midrst_cnt", b1.cnt, 0);
        chk("midrst_done", b1.done, 0);
        sq.delete(); act.delete(); rsp_pend = 0;
        b1.req = 2'b00;
        tick(3);
        reset = 1;
        // pointer back at 0; req[0] dropped after grant still completes
        b1.req_dat = 16'h4433;
        push(0, 16'h0033, cyc + 1);
        push(1, 16'h0044, cyc + 25);
        b1.req = 2'b11;
        k = 0;
        while (sq.size() == 2 && k < 5) begin tick(); k++; end
        b1.req = 2'b10;
        wait_grants(40);
        b1.req = 2'b00;
        wait_all(40);

        // 16-bit frame
        b2.req_dat = 32'h0000_1234;
        b2.req = 2'b01;
        k = 0;
        while (n2 == 0 && k < 80) begin tick(); k++; end
        b2.req = 2'b00;
        chk("frame16_completed", n2, 1);
        tick(10);

        chk("ss_n_invariant", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
